// File: rtl/ram_stack_tos_if.sv
// ram_stack_tos_if: command and status bundle for the RAM-backed TOS stack.
// Optional macro RAM_STACK_HWM_EN adds the hwm (high-water mark) status signal.
//
// Handshake: there is no valid/ready pair. The stack accepts one command
// (we, delta, wd, clr_err) on every rising clk edge. HOLD (we=0, delta=00) is
// the idle command. All status outputs are registered and reflect the command
// from the previous edge. Illegal commands are dropped and flagged instead of
// being back-pressured.
interface ram_stack_tos_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 10
);
  logic             we;
  logic [1:0]       delta;
  logic [WIDTH-1:0] wd;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             bad_op;
`ifdef RAM_STACK_HWM_EN
  logic [CW-1:0]    hwm;

  modport master (output we, delta, wd, clr_err,
                  input  tos, nos, count, empty, full, ovf, unf, bad_op, hwm);
  modport slave  (input  we, delta, wd, clr_err,
                  output tos, nos, count, empty, full, ovf, unf, bad_op, hwm);
`else
  modport master (output we, delta, wd, clr_err,
                  input  tos, nos, count, empty, full, ovf, unf, bad_op);
  modport slave  (input  we, delta, wd, clr_err,
                  output tos, nos, count, empty, full, ovf, unf, bad_op);
`endif
endinterface

// File: rtl/ram_stack_tos.sv
// ram_stack_tos: RAM-based stack with TOS held in a register and NOS read
// from a single-port synchronous RAM, so both operands are available every
// cycle. Tracks depth, full/empty, and sticky ovf/unf/bad_op errors.
// Optional macro RAM_STACK_HWM_EN adds a high-water-mark output (hwm).
module ram_stack_tos #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int INFER = 0,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  ram_stack_tos_if.slave sif
);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [CW-1:0]    count_q, ncount;
  logic             ovf_q, unf_q, bad_q;
  logic [WIDTH-1:0] byp_q;
  logic             byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0] nos_w, ram_rdata;
  logic [AW-1:0]    ram_addr;
  logic             ram_we;

  logic op_push, op_rep, op_pop, op_popwr, op_hold, op_bad;
  logic push_ok, rep_ok, pop_ok, popwr_ok;
  logic ovf_set, unf_set;
  logic is_full, is_empty;

  // Command decode; combinations outside the listed set do nothing.
  assign op_push  =  sif.we && (sif.delta == 2'b01);
  assign op_rep   =  sif.we && (sif.delta == 2'b00);
  assign op_pop   = !sif.we && (sif.delta == 2'b11);
  assign op_popwr =  sif.we && (sif.delta == 2'b11);
  assign op_hold  = !sif.we && (sif.delta == 2'b00);
  assign op_bad   = (sif.delta == 2'b10);

  assign is_full  = (count_q == FULL);
  assign is_empty = (count_q == '0);

  assign push_ok  = op_push  && !is_full;
  assign rep_ok   = op_rep   && !is_empty;
  assign pop_ok   = op_pop   && !is_empty;
  assign popwr_ok = op_popwr && (count_q >= TWO);

  assign ovf_set  = op_push && is_full;
  assign unf_set  = (op_pop && is_empty) || (op_popwr && (count_q < TWO)) ||
                    (op_rep && is_empty);

  // Right after a push the RAM read of the just-written slot may return the
  // old contents, so the pushed-down TOS is served from the bypass register.
  assign nos_w = byp_sel_q ? byp_q : ram_rdata;

  // Next count and next TOS value.
  always_comb begin
    ncount = count_q;
    if (push_ok)                 ncount = count_q + ONE;
    else if (pop_ok || popwr_ok) ncount = count_q - ONE;
    tos_d = tos_q;
    if (push_ok || rep_ok || popwr_ok) tos_d = sif.wd;
    else if (pop_ok)                   tos_d = (ncount == '0) ? '0 : nos_w;
  end

  // The address always points at the next NOS slot; on a push it is also
  // the slot receiving the old TOS, so one RAM port suffices.
  assign ram_addr  = AW'(ncount - TWO);
  assign ram_we    = push_ok && !is_empty;
  assign byp_sel_d = push_ok || (byp_sel_q && op_hold);

  // Stack state and sticky error flags. The bypass select resets to 1 so
  // nos reads the cleared bypass register (0) before the RAM holds data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      bad_q     <= 1'b0;
      byp_q     <= '0;
      byp_sel_q <= 1'b1;
    end else begin
      tos_q     <= tos_d;
      count_q   <= ncount;
      ovf_q     <= ovf_set | (ovf_q & ~sif.clr_err);
      unf_q     <= unf_set | (unf_q & ~sif.clr_err);
      bad_q     <= op_bad  | (bad_q & ~sif.clr_err);
      byp_sel_q <= byp_sel_d;
      if (push_ok) byp_q <= tos_q;
    end
  end

`ifdef RAM_STACK_HWM_EN
  logic [CW-1:0] hwm_q;

  // High-water mark follows count; clr_err restarts it from the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              hwm_q <= '0;
    else if (sif.clr_err) hwm_q <= ncount;
    else if (ncount > hwm_q) hwm_q <= ncount;
  end

  assign sif.hwm = hwm_q;
`endif

  sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INFER (INFER)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (tos_q),
    .rdata_o (ram_rdata)
  );

  assign sif.tos    = tos_q;
  assign sif.nos    = nos_w;
  assign sif.count  = count_q;
  assign sif.empty  = is_empty;
  assign sif.full   = is_full;
  assign sif.ovf    = ovf_q;
  assign sif.unf    = unf_q;
  assign sif.bad_op = bad_q;
endmodule

// sram: single-port RAM with synchronous read. INFER=1 gives a plain
// inferred array (read-old-data); INFER=0 models the vendor block
// (write-through). The stack does not depend on either collision behaviour.
module sram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  parameter int INFER = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  generate
    if (INFER != 0) begin : g_infer
      // Inferred RAM: write and registered read of the previous contents.
      always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
      end
    end else begin : g_vendor
      // Vendor-style block: registered read returns the data being written.
      always_ff @(posedge clk_i) begin
        if (we_i) begin
          mem_q[addr_i] <= wdata_i;
          rdata_q       <= wdata_i;
        end else begin
          rdata_q       <= mem_q[addr_i];
        end
      end
    end
  endgenerate

  assign rdata_o = rdata_q;
endmodule

// File: tb/tb_ram_stack_tos.sv
// tb_ram_stack_tos: directed and randomized checks of ram_stack_tos against a
// queue-based stack model. Define RAM_STACK_HWM_EN to cover the hwm output.
module tb_ram_stack_tos;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_stack_tos_if #(.WIDTH(WIDTH), .CW(CW)) sif ();

  ram_stack_tos #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INFER (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] exp_q[$];   // stack contents, index 0 = bottom
  bit m_ovf, m_unf, m_bad;
  int m_hwm;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cmp_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 0; m_unf = 0; m_bad = 0; m_hwm = 0;
  endtask

  task automatic model_step(input logic w, input logic [1:0] d,
                            input logic [WIDTH-1:0] data, input logic c);
    int n;
    bit so, su, sb;
    n = exp_q.size();
    so = 0; su = 0; sb = 0;
    if (d == 2'b10) sb = 1;
    else if (w && d == 2'b01) begin
      if (n == DEPTH) so = 1; else exp_q.push_back(data);
    end else if (w && d == 2'b00) begin
      if (n == 0) su = 1; else exp_q[n-1] = data;
    end else if (!w && d == 2'b11) begin
      if (n == 0) su = 1; else void'(exp_q.pop_back());
    end else if (w && d == 2'b11) begin
      if (n < 2) su = 1;
      else begin
        void'(exp_q.pop_back());
        exp_q[n-2] = data;
      end
    end
    m_ovf = so | (m_ovf & !c);
    m_unf = su | (m_unf & !c);
    m_bad = sb | (m_bad & !c);
    if (c) m_hwm = exp_q.size();
    else if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic [1:0] d,
                      input logic [WIDTH-1:0] data, input logic c);
    sif.we = w; sif.delta = d; sif.wd = data; sif.clr_err = c;
    @(posedge clk);
    model_step(w, d, data, c);
    @(negedge clk);
  endtask

  task automatic push(input logic [WIDTH-1:0] data); step(1'b1, 2'b01, data, 1'b0); endtask
  task automatic pop();  step(1'b0, 2'b11, '0, 1'b0); endtask
  task automatic hold(); step(1'b0, 2'b00, '0, 1'b0); endtask
  task automatic clr();  step(1'b0, 2'b00, '0, 1'b1); endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_n = exp_q.size();
      check("tos",   sif.tos,   (cmp_n > 0) ? 32'(exp_q[cmp_n-1]) : 32'd0);
      if (cmp_n >= 2) check("nos", sif.nos, 32'(exp_q[cmp_n-2]));
      check("count", sif.count, cmp_n);
      check("empty", sif.empty, cmp_n == 0);
      check("full",  sif.full,  cmp_n == DEPTH);
      check("ovf",   sif.ovf,   m_ovf);
      check("unf",   sif.unf,   m_unf);
      check("bad_op", sif.bad_op, m_bad);
`ifdef RAM_STACK_HWM_EN
      check("hwm",   sif.hwm,   m_hwm);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic w;
    logic [1:0] d;
    rst = 1'b1;
    sif.we = 1'b0; sif.delta = 2'b00; sif.wd = '0; sif.clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_count", sif.count, 0);
    check("rst_tos",   sif.tos,   0);
    check("rst_nos",   sif.nos,   0);
    check("rst_empty", sif.empty, 1);
    check("rst_flags", {sif.ovf, sif.unf, sif.bad_op}, 0);
`ifdef RAM_STACK_HWM_EN
    check("rst_hwm",   sif.hwm,   0);
`endif
    chk_en = 1'b1;

    // Back-to-back pushes exercise the bypass path.
    push(16'h1111); push(16'h2222); push(16'h3333);
    check("p3_count", sif.count, 3);
    check("p3_tos",   sif.tos,   16'h3333);
    check("p3_nos",   sif.nos,   16'h2222);
    hold();
    pop();
    check("pop1_tos", sif.tos, 16'h2222);
    check("pop1_nos", sif.nos, 16'h1111);
    pop();
    check("pop2_tos",   sif.tos,   16'h1111);
    check("pop2_count", sif.count, 1);
    pop();
    check("pop3_count", sif.count, 0);
    check("pop3_tos",   sif.tos,   0);
    check("pop3_empty", sif.empty, 1);

    // Pop-and-write.
    push(16'h0005); push(16'h0007);
    step(1'b1, 2'b11, 16'h000C, 1'b0);
    check("popwr_count", sif.count, 1);
    check("popwr_tos",   sif.tos,   16'h000C);
    check("popwr_unf",   sif.unf,   0);
    step(1'b1, 2'b11, 16'h00AA, 1'b0);
    check("popwr_bad_unf", sif.unf, 1);
    check("popwr_bad_tos", sif.tos, 16'h000C);
    clr();
    check("clr_unf", sif.unf, 0);
    pop();

    // Fill, overflow, drain in LIFO order.
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    check("fill_full", sif.full, 1);
    push(16'hA005);
    check("ovf_flag",  sif.ovf,   1);
    check("ovf_tos",   sif.tos,   16'hA004);
    check("ovf_count", sif.count, 4);
    for (int i = 0; i < 4; i++) begin
      check("lifo_tos", sif.tos, 16'hA004 - i);
      pop();
    end
    check("drain_empty", sif.empty, 1);
    clr();

    // Error set wins over a simultaneous clear.
    step(1'b0, 2'b11, '0, 1'b1);
    check("tie_unf", sif.unf, 1);
    clr();

    // Reserved delta and replace.
    push(16'hB001); push(16'hB002);
    step(1'b1, 2'b10, 16'hDEAD, 1'b0);
    check("bad_flag", sif.bad_op, 1);
    check("bad_tos",  sif.tos,    16'hB002);
    step(1'b1, 2'b00, 16'hBEEF, 1'b0);
    check("rep_tos", sif.tos, 16'hBEEF);
    check("rep_nos", sif.nos, 16'hB001);
    pop(); pop(); clr();

    // High-water mark and mid-push reset.
    push(16'h0001); push(16'h0002); push(16'h0003);
    pop(); pop(); push(16'h0004);
`ifdef RAM_STACK_HWM_EN
    check("hwm_peak", sif.hwm, 3);
`endif
    clr();
`ifdef RAM_STACK_HWM_EN
    check("hwm_clr", sif.hwm, 2);
`endif
    push(16'h0005);
    sif.we = 1'b1; sif.delta = 2'b01; sif.wd = 16'h0006; sif.clr_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_count", sif.count, 0);
    check("mid_rst_tos",   sif.tos,   0);
`ifdef RAM_STACK_HWM_EN
    check("mid_rst_hwm",   sif.hwm,   0);
`endif
    @(negedge clk);
    sif.we = 1'b0; sif.delta = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      w = 1'($urandom_range(0, 1));
      d = 2'($urandom_range(0, 3));
      if (!w && d == 2'b01) d = 2'b00;
      step(w, d, 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
